// File: rtl/serial_word_rx_pkg.sv
// Shared state encoding and helper functions for the serial word receiver.
package serial_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    PAR  = 2'd2,
    HOLD = 2'd3
  } rx_state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  // Even parity: the data bits plus the parity bit must XOR to zero.
  function automatic logic even_parity_err(input logic [31:0] word, input logic par_bit);
    return (^word) ^ par_bit;
  endfunction

endpackage

// File: rtl/serial_word_rx_if.sv
// Serial input and parallel valid/ready output bundle of serial_word_rx.
interface serial_word_rx_if #(
  parameter int WIDTH = 8
);
  logic             Start;
  logic             Bit_In;
  logic             Bit_Valid;
  logic             Out_Ready;
  logic [WIDTH-1:0] Data_Out;
  logic             Out_Valid;
  logic             Busy;
  logic             Overrun;
  logic             Parity_Err;

  modport master (
    output Start, Bit_In, Bit_Valid, Out_Ready,
    input  Data_Out, Out_Valid, Busy, Overrun, Parity_Err
  );

  modport slave (
    input  Start, Bit_In, Bit_Valid, Out_Ready,
    output Data_Out, Out_Valid, Busy, Overrun, Parity_Err
  );
endinterface

// File: rtl/serial_word_rx_sipo.sv
// Right-shift (LSB-first) serial-in register with synchronous clear and shift enable.
// Its next-state value is exposed so the owner can capture a word on the final shift edge.
module sipo_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] sr_next
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (clr) begin
      sr_d = {WIDTH{1'b0}};
    end else if (shift_en) begin
      sr_d = {bit_in, sr_q[WIDTH-1:1]};
    end else begin
      sr_d = sr_q;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sr_q <= {WIDTH{1'b0}};
    end else begin
      sr_q <= sr_d;
    end
  end

  assign sr_next = sr_d;

endmodule

// File: rtl/serial_word_rx.sv
// LSB-first serial word receiver with a valid/ready parallel output.
// Define PARITY_CHECK_EN to add a trailing even-parity bit per frame.
module serial_word_rx #(
  parameter int WIDTH = 8
) (
  input logic             Clk,
  input logic             Reset,
  serial_word_rx_if.slave bus
);
  import serial_rx_pkg::*;

  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  rx_state_t        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] sr_next;
  logic             sr_clr;
  logic             sr_shift;
`ifdef PARITY_CHECK_EN
  logic             perr_q, perr_d;
`endif

  // A Start refused in HOLD must not disturb the word being presented.
  assign sr_clr   = bus.Start && ((state_q != HOLD) || bus.Out_Ready);
  assign sr_shift = (state_q == RECV) && bus.Bit_Valid && !bus.Start;

  sipo_shift_reg #(.WIDTH(WIDTH)) u_sipo (
    .Clk      (Clk),
    .Reset    (Reset),
    .clr      (sr_clr),
    .shift_en (sr_shift),
    .bit_in   (bus.Bit_In),
    .sr_next  (sr_next)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
`ifdef PARITY_CHECK_EN
    perr_d    = perr_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          state_d = RECV;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      RECV: begin
        if (bus.Start) begin
          cnt_d = {CW{1'b0}};
        end else if (bus.Bit_Valid) begin
          if (cnt_q == LAST) begin
            cnt_d = {CW{1'b0}};
`ifdef PARITY_CHECK_EN
            state_d = PAR;
`else
            data_d  = sr_next;
            valid_d = 1'b1;
            state_d = HOLD;
`endif
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
`ifdef PARITY_CHECK_EN
      PAR: begin
        if (bus.Start) begin
          state_d = RECV;
          cnt_d   = {CW{1'b0}};
        end else if (bus.Bit_Valid) begin
          data_d  = sr_next;
          perr_d  = even_parity_err(32'(sr_next), bus.Bit_In);
          valid_d = 1'b1;
          state_d = HOLD;
        end else begin
          state_d = PAR;
        end
      end
`endif
      HOLD: begin
        if (bus.Out_Ready) begin
          valid_d = 1'b0;
`ifdef PARITY_CHECK_EN
          perr_d  = 1'b0;
`endif
          if (bus.Start) begin
            state_d = RECV;
            cnt_d   = {CW{1'b0}};
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (bus.Start) begin
            overrun_d = 1'b1;
          end else begin
            overrun_d = overrun_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CW{1'b0}};
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= {CW{1'b0}};
      data_q    <= {WIDTH{1'b0}};
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
`ifdef PARITY_CHECK_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
`ifdef PARITY_CHECK_EN
      perr_q    <= perr_d;
`endif
    end
  end

  assign bus.Data_Out  = data_q;
  assign bus.Out_Valid = valid_q;
  assign bus.Busy      = (state_q == RECV) || (state_q == PAR);
  assign bus.Overrun   = overrun_q;
`ifdef PARITY_CHECK_EN
  assign bus.Parity_Err = perr_q;
`else
  assign bus.Parity_Err = 1'b0;
`endif

endmodule
